// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues in-order imem word reads and
// queues returned words with their PCs for decode. Optional build macro: ALIGN_CHECK_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misaligned
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = CW + 4;  // discard can pile up over back-to-back redirects

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t [QUEUE_DEPTH-1:0]       q;
  logic   [QUEUE_DEPTH-1:0][31:0] pcf;
  logic [AW-1:0] q_rd, q_wr, pcf_rd, pcf_wr;
  logic [CW-1:0] occ, inflight;
  logic [DW-1:0] discard;
  logic [31:0]   fetch_pc, redir_tgt;
  logic          live, halted, out_en;
  logic          pop, accept, rsp_live, room;
  logic [CW:0]   demand;

  // live keeps every output quiet for the first cycle after reset
  assign out_en   = live & ~rst;
  assign pop      = instr_valid & instr_ready;
  assign accept   = imem_req_valid & imem_req_ready;
  assign rsp_live = imem_rsp_valid & (discard == '0);
  assign demand   = {1'b0, occ} + {1'b0, inflight} - {{CW{1'b0}}, pop};
  assign room     = demand < (CW+1)'(QUEUE_DEPTH);

  assign imem_req_valid = out_en & ~redirect_valid & ~halted & room;
  assign imem_addr      = out_en ? fetch_pc : '0;
  assign instr_valid    = out_en & (occ != '0);
  assign instr          = out_en ? q[q_rd].word : '0;
  assign instr_pc       = out_en ? q[q_rd].pc : '0;

`ifdef ALIGN_CHECK_EN
  assign redir_tgt = redirect_pc;
  always_ff @(posedge clk) begin
    if (rst)                 halted <= 1'b0;
    else if (redirect_valid) halted <= |redirect_pc[1:0];
  end
`else
  assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign halted    = 1'b0;
`endif
  assign fetch_misaligned = out_en & halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      live     <= 1'b0;
      fetch_pc <= RESET_PC;
      q_rd     <= '0;
      q_wr     <= '0;
      pcf_rd   <= '0;
      pcf_wr   <= '0;
      occ      <= '0;
      inflight <= '0;
      discard  <= '0;
    end else begin
      live <= 1'b1;
      if (redirect_valid) begin
        // every live request still out, minus one answered this cycle, is dropped
        q_rd     <= '0;
        q_wr     <= '0;
        pcf_rd   <= '0;
        pcf_wr   <= '0;
        occ      <= '0;
        inflight <= '0;
        discard  <= discard + DW'(inflight) - DW'(imem_rsp_valid);
        fetch_pc <= redir_tgt;
      end else begin
        if (accept) begin
          pcf[pcf_wr] <= fetch_pc;
          pcf_wr      <= pcf_wr + 1'b1;
          fetch_pc    <= fetch_pc + 32'd4;
        end
        if (rsp_live) begin
          q[q_wr] <= {pcf[pcf_rd], imem_rsp_data};
          q_wr    <= q_wr + 1'b1;
          pcf_rd  <= pcf_rd + 1'b1;
        end
        if (pop) q_rd <= q_rd + 1'b1;
        if (imem_rsp_valid && !rsp_live) discard <= discard - 1'b1;
        occ      <= occ + CW'(rsp_live) - CW'(pop);
        inflight <= inflight + CW'(accept) - CW'(rsp_live);
      end
    end
  end

  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (inflight != '0 || discard != '0));

endmodule
